// File: rtl/pipe_hazard_ctrl.sv
// Hazard and stall/flush controller for the Ak-16b 5-stage pipeline: load-use
// interlock, taken-branch flush sequencing, multi-cycle EX hold, stall counter.
module pipe_hazard_ctrl #(
    parameter int BR_FLUSH_CYCLES = 1,
    parameter int MC_TIMEOUT      = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  id_rs1,
    input  logic [3:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic [3:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        ex_branch_taken,
    input  logic        mc_start,
    input  logic        mc_done,
    output logic        pc_stall,
    output logic        stall_if_id,
    output logic        flush_if_id,
    output logic        stall_ex,
    output logic        flush_ex,
    output logic        flush_mem,
    output logic [1:0]  state,
    output logic        mc_error,
    output logic [15:0] stall_cycles
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        BR_FLUSH = 2'd1,
        MC_WAIT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  flush_cnt_q, flush_cnt_d;
    logic [7:0]  mc_cnt_q, mc_cnt_d;
    logic        mc_error_q, mc_error_d;
    logic [15:0] stall_cycles_q, stall_cycles_d;
    logic        load_use;
    logic        timeout_hit;

    // Register r0 is hardwired to zero, so it can never carry a load result.
    assign load_use = ex_mem_read && (ex_rd != 4'd0) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));

    always_comb begin
        state_d        = state_q;
        flush_cnt_d    = flush_cnt_q;
        mc_cnt_d       = mc_cnt_q;
        mc_error_d     = mc_error_q;
        timeout_hit    = 1'b0;
        pc_stall       = 1'b0;
        stall_if_id    = 1'b0;
        flush_if_id    = 1'b0;
        stall_ex       = 1'b0;
        flush_ex       = 1'b0;
        flush_mem      = 1'b0;

        case (state_q)
            RUN: begin
                if (ex_branch_taken) begin
                    flush_if_id = 1'b1;
                    flush_ex    = 1'b1;
                    if (BR_FLUSH_CYCLES > 1) begin
                        state_d     = BR_FLUSH;
                        flush_cnt_d = 3'(BR_FLUSH_CYCLES - 1);
                    end
                end else if (mc_start && !mc_done) begin
                    pc_stall    = 1'b1;
                    stall_if_id = 1'b1;
                    stall_ex    = 1'b1;
                    flush_mem   = 1'b1;
                    state_d     = MC_WAIT;
                    mc_cnt_d    = 8'd1;
                end else if (!mc_start && load_use) begin
                    pc_stall    = 1'b1;
                    stall_if_id = 1'b1;
                    flush_ex    = 1'b1;
                end
            end
            BR_FLUSH: begin
                flush_if_id = 1'b1;
                flush_ex    = 1'b1;
                flush_cnt_d = flush_cnt_q - 3'd1;
                if (flush_cnt_q <= 3'd1) begin
                    state_d = RUN;
                end
            end
            MC_WAIT: begin
                // The entry cycle already counted as one, so the abort lands on
                // the MC_TIMEOUT-th cycle of the operation.
                if (mc_done) begin
                    state_d = RUN;
                end else if (mc_cnt_q >= 8'(MC_TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    mc_error_d  = 1'b1;
                    state_d     = RUN;
                end else begin
                    pc_stall    = 1'b1;
                    stall_if_id = 1'b1;
                    stall_ex    = 1'b1;
                    flush_mem   = 1'b1;
                    mc_cnt_d    = mc_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase

        if (!rst_n) begin
            timeout_hit = 1'b0;
            pc_stall    = 1'b0;
            stall_if_id = 1'b0;
            flush_if_id = 1'b0;
            stall_ex    = 1'b0;
            flush_ex    = 1'b0;
            flush_mem   = 1'b0;
        end

        stall_cycles_d = stall_cycles_q;
        if (pc_stall && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= RUN;
            flush_cnt_q    <= 3'd0;
            mc_cnt_q       <= 8'd0;
            mc_error_q     <= 1'b0;
            stall_cycles_q <= 16'd0;
        end else begin
            state_q        <= state_d;
            flush_cnt_q    <= flush_cnt_d;
            mc_cnt_q       <= mc_cnt_d;
            mc_error_q     <= mc_error_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign state        = state_q;
    assign mc_error     = mc_error_q | timeout_hit;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus random
// stimulus compared against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int BR = 3;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  id_rs1, id_rs2, ex_rd;
    logic        id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
    logic        mc_start, mc_done;
    logic        pc_stall, stall_if_id, flush_if_id, stall_ex, flush_ex, flush_mem;
    logic [1:0]  state;
    logic        mc_error;
    logic [15:0] stall_cycles;
    logic [5:0]  ctl;

    int total = 0;
    int bad   = 0;

    pipe_hazard_ctrl #(.BR_FLUSH_CYCLES(BR), .MC_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_branch_taken(ex_branch_taken),
        .mc_start(mc_start), .mc_done(mc_done),
        .pc_stall(pc_stall), .stall_if_id(stall_if_id), .flush_if_id(flush_if_id),
        .stall_ex(stall_ex), .flush_ex(flush_ex), .flush_mem(flush_mem),
        .state(state), .mc_error(mc_error), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    // Order: pc_stall, stall_if_id, flush_if_id, stall_ex, flush_ex, flush_mem
    assign ctl = {pc_stall, stall_if_id, flush_if_id, stall_ex, flush_ex, flush_mem};

    task automatic clear_inputs;
        id_rs1 = 4'd0; id_rs2 = 4'd0; ex_rd = 4'd0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0;
        ex_branch_taken = 1'b0; mc_start = 1'b0; mc_done = 1'b0;
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset;
        clear_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic set_load_use;
        ex_mem_read = 1'b1; ex_rd = 4'd3; id_rs2 = 4'd3; id_uses_rs2 = 1'b1;
        id_rs1 = 4'd5; id_uses_rs1 = 1'b1;
    endtask

    task automatic test_reset;
        clear_inputs();
        mc_start = 1'b1; ex_branch_taken = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        total++; if (ctl !== 6'b000000) begin bad++; $display("[TB] FAIL reset_ctl: got %b expected %b", ctl, 6'b000000); end
        total++; if (state !== 2'd0) begin bad++; $display("[TB] FAIL reset_state: got %0d expected 0", state); end
        total++; if (mc_error !== 1'b0) begin bad++; $display("[TB] FAIL reset_err: got %b expected 0", mc_error); end
        total++; if (stall_cycles !== 16'd0) begin bad++; $display("[TB] FAIL reset_cnt: got %0d expected 0", stall_cycles); end
        clear_inputs();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_load_use;
        do_reset();
        set_load_use();
        #1;
        total++; if (ctl !== 6'b110010) begin bad++; $display("[TB] FAIL lu_ctl: got %b expected %b", ctl, 6'b110010); end
        tick();
        clear_inputs();
        #1;
        total++; if (ctl !== 6'b000000) begin bad++; $display("[TB] FAIL lu_after: got %b expected %b", ctl, 6'b000000); end
        total++; if (stall_cycles !== 16'd1) begin bad++; $display("[TB] FAIL lu_cnt: got %0d expected 1", stall_cycles); end
        tick();
        ex_mem_read = 1'b1; ex_rd = 4'd0; id_rs2 = 4'd0; id_uses_rs2 = 1'b1;
        #1;
        total++; if (ctl !== 6'b000000) begin bad++; $display("[TB] FAIL lu_r0: got %b expected %b", ctl, 6'b000000); end
        tick();
        clear_inputs();
        ex_mem_read = 1'b1; ex_rd = 4'd4; id_rs1 = 4'd4; id_uses_rs1 = 1'b0;
        #1;
        total++; if (ctl !== 6'b000000) begin bad++; $display("[TB] FAIL lu_unused: got %b expected %b", ctl, 6'b000000); end
        tick();
        clear_inputs();
        #1;
        total++; if (stall_cycles !== 16'd1) begin bad++; $display("[TB] FAIL lu_cnt2: got %0d expected 1", stall_cycles); end
    endtask

    task automatic test_branch;
        do_reset();
        ex_branch_taken = 1'b1;
        #1;
        total++; if (ctl !== 6'b001010) begin bad++; $display("[TB] FAIL br_ctl0: got %b expected %b", ctl, 6'b001010); end
        total++; if (state !== 2'd0) begin bad++; $display("[TB] FAIL br_state0: got %0d expected 0", state); end
        tick();
        clear_inputs();
        set_load_use();
        for (int i = 0; i < BR - 1; i++) begin
            #1;
            total++; if (ctl !== 6'b001010) begin bad++; $display("[TB] FAIL br_ctl%0d: got %b expected %b", i + 1, ctl, 6'b001010); end
            total++; if (state !== 2'd1) begin bad++; $display("[TB] FAIL br_state%0d: got %0d expected 1", i + 1, state); end
            tick();
        end
        clear_inputs();
        #1;
        total++; if (ctl !== 6'b000000) begin bad++; $display("[TB] FAIL br_end_ctl: got %b expected %b", ctl, 6'b000000); end
        total++; if (state !== 2'd0) begin bad++; $display("[TB] FAIL br_end_state: got %0d expected 0", state); end
        total++; if (stall_cycles !== 16'd0) begin bad++; $display("[TB] FAIL br_cnt: got %0d expected 0", stall_cycles); end
    endtask

    task automatic test_branch_load_use;
        do_reset();
        set_load_use();
        ex_branch_taken = 1'b1;
        #1;
        total++; if (ctl !== 6'b001010) begin bad++; $display("[TB] FAIL brlu_ctl: got %b expected %b", ctl, 6'b001010); end
        tick();
        clear_inputs();
        repeat (BR) tick();
        #1;
        total++; if (stall_cycles !== 16'd0) begin bad++; $display("[TB] FAIL brlu_cnt: got %0d expected 0", stall_cycles); end
    endtask

    task automatic test_mc_done;
        do_reset();
        mc_start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if (ctl !== 6'b110101) begin bad++; $display("[TB] FAIL mc_ctl%0d: got %b expected %b", i, ctl, 6'b110101); end
            total++; if (state !== ((i == 0) ? 2'd0 : 2'd2)) begin bad++; $display("[TB] FAIL mc_state%0d: got %0d", i, state); end
            tick();
        end
        mc_done = 1'b1;
        #1;
        total++; if (ctl !== 6'b000000) begin bad++; $display("[TB] FAIL mc_done_ctl: got %b expected %b", ctl, 6'b000000); end
        tick();
        clear_inputs();
        #1;
        total++; if (state !== 2'd0) begin bad++; $display("[TB] FAIL mc_done_state: got %0d expected 0", state); end
        total++; if (stall_cycles !== 16'd4) begin bad++; $display("[TB] FAIL mc_cnt: got %0d expected 4", stall_cycles); end
        mc_start = 1'b1; mc_done = 1'b1;
        #1;
        total++; if (ctl !== 6'b000000) begin bad++; $display("[TB] FAIL mc_1cyc_ctl: got %b expected %b", ctl, 6'b000000); end
        tick();
        clear_inputs();
        #1;
        total++; if (state !== 2'd0) begin bad++; $display("[TB] FAIL mc_1cyc_state: got %0d expected 0", state); end
        total++; if (stall_cycles !== 16'd4) begin bad++; $display("[TB] FAIL mc_1cyc_cnt: got %0d expected 4", stall_cycles); end
    endtask

    task automatic test_mc_timeout;
        do_reset();
        mc_start = 1'b1;
        for (int i = 0; i < TO - 1; i++) begin
            if (i > 0) begin
                ex_branch_taken = 1'b1;
                set_load_use();
            end
            #1;
            total++; if (ctl !== 6'b110101) begin bad++; $display("[TB] FAIL to_ctl%0d: got %b expected %b", i, ctl, 6'b110101); end
            total++; if (mc_error !== 1'b0) begin bad++; $display("[TB] FAIL to_err_early%0d: got %b expected 0", i, mc_error); end
            tick();
        end
        #1;
        total++; if (ctl !== 6'b000000) begin bad++; $display("[TB] FAIL to_abort_ctl: got %b expected %b", ctl, 6'b000000); end
        total++; if (mc_error !== 1'b1) begin bad++; $display("[TB] FAIL to_err: got %b expected 1", mc_error); end
        total++; if (state !== 2'd2) begin bad++; $display("[TB] FAIL to_state_abort: got %0d expected 2", state); end
        clear_inputs();
        tick();
        #1;
        total++; if (state !== 2'd0) begin bad++; $display("[TB] FAIL to_state_run: got %0d expected 0", state); end
        total++; if (stall_cycles !== 16'(TO - 1)) begin bad++; $display("[TB] FAIL to_cnt: got %0d expected %0d", stall_cycles, TO - 1); end
        tick();
        tick();
        #1;
        total++; if (mc_error !== 1'b1) begin bad++; $display("[TB] FAIL to_sticky: got %b expected 1", mc_error); end
    endtask

    // Runs straight after the timeout test so reset must also clear mc_error.
    task automatic test_reset_mid_op;
        clear_inputs();
        mc_start = 1'b1;
        tick();
        tick();
        #1;
        total++; if (state !== 2'd2) begin bad++; $display("[TB] FAIL rmid_pre: got %0d expected 2", state); end
        rst_n = 1'b0;
        #1;
        total++; if (ctl !== 6'b000000) begin bad++; $display("[TB] FAIL rmid_mc_ctl: got %b expected %b", ctl, 6'b000000); end
        total++; if (state !== 2'd0) begin bad++; $display("[TB] FAIL rmid_mc_state: got %0d expected 0", state); end
        total++; if (mc_error !== 1'b0) begin bad++; $display("[TB] FAIL rmid_err: got %b expected 0", mc_error); end
        total++; if (stall_cycles !== 16'd0) begin bad++; $display("[TB] FAIL rmid_cnt: got %0d expected 0", stall_cycles); end
        clear_inputs();
        tick();
        rst_n = 1'b1;
        ex_branch_taken = 1'b1;
        tick();
        #1;
        total++; if (state !== 2'd1) begin bad++; $display("[TB] FAIL rmid_br_pre: got %0d expected 1", state); end
        rst_n = 1'b0;
        #1;
        total++; if (ctl !== 6'b000000) begin bad++; $display("[TB] FAIL rmid_br_ctl: got %b expected %b", ctl, 6'b000000); end
        total++; if (state !== 2'd0) begin bad++; $display("[TB] FAIL rmid_br_state: got %0d expected 0", state); end
        clear_inputs();
        tick();
        rst_n = 1'b1;
        #1;
        total++; if (ctl !== 6'b000000) begin bad++; $display("[TB] FAIL rmid_release: got %b expected %b", ctl, 6'b000000); end
    endtask

    task automatic test_saturation;
        do_reset();
        set_load_use();
        repeat (65534) tick();
        #1;
        total++; if (stall_cycles !== 16'hFFFE) begin bad++; $display("[TB] FAIL sat_fffe: got %h expected fffe", stall_cycles); end
        tick();
        #1;
        total++; if (stall_cycles !== 16'hFFFF) begin bad++; $display("[TB] FAIL sat_ffff: got %h expected ffff", stall_cycles); end
        repeat (3) tick();
        #1;
        total++; if (stall_cycles !== 16'hFFFF) begin bad++; $display("[TB] FAIL sat_hold: got %h expected ffff", stall_cycles); end
        total++; if (pc_stall !== 1'b1) begin bad++; $display("[TB] FAIL sat_stall: got %b expected 1", pc_stall); end
        clear_inputs();
    endtask

    // Model tracks remaining flush cycles and stall cycles already paid by a
    // pending multi-cycle op, deriving outputs from the hazard rules directly.
    task automatic test_random;
        int         br_left, mc_paid, stalls, n_br, n_paid;
        bit         mc_on, err, err_now, n_on, lu;
        logic [5:0] exp_ctl;
        logic [1:0] exp_state;
        do_reset();
        br_left = 0; mc_paid = 0; stalls = 0; mc_on = 0; err = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                rst_n = 1'b0;
                #1;
                total++; if (ctl !== 6'b000000) begin bad++; $display("[TB] FAIL rnd_rst_ctl @%0d: got %b expected %b", n, ctl, 6'b000000); end
                total++; if ({state, mc_error, stall_cycles} !== 19'd0) begin bad++; $display("[TB] FAIL rnd_rst_regs @%0d: got %0d/%b/%0d expected zeros", n, state, mc_error, stall_cycles); end
                br_left = 0; mc_paid = 0; stalls = 0; mc_on = 0; err = 0;
                tick();
                rst_n = 1'b1;
                continue;
            end
            id_rs1 = 4'($urandom_range(0, 3));
            id_rs2 = 4'($urandom_range(0, 3));
            ex_rd  = 4'($urandom_range(0, 3));
            id_uses_rs1     = ($urandom_range(0, 1) == 1);
            id_uses_rs2     = ($urandom_range(0, 1) == 1);
            ex_mem_read     = ($urandom_range(0, 1) == 1);
            ex_branch_taken = ($urandom_range(0, 7) == 0);
            mc_start        = ($urandom_range(0, 3) == 0);
            mc_done         = ($urandom_range(0, 5) == 0);

            lu = ex_mem_read && (ex_rd != 0) &&
                 ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
            exp_ctl = 6'b000000; err_now = 0;
            n_br = br_left; n_on = mc_on; n_paid = mc_paid;
            if (br_left > 0) begin
                exp_state = 2'd1; exp_ctl = 6'b001010; n_br = br_left - 1;
            end else if (mc_on) begin
                exp_state = 2'd2;
                if (mc_done) n_on = 0;
                else if (mc_paid == TO - 1) begin err_now = 1; n_on = 0; end
                else begin exp_ctl = 6'b110101; n_paid = mc_paid + 1; end
            end else begin
                exp_state = 2'd0;
                if (ex_branch_taken) begin exp_ctl = 6'b001010; n_br = BR - 1; end
                else if (mc_start && !mc_done) begin exp_ctl = 6'b110101; n_on = 1; n_paid = 1; end
                else if (!mc_start && lu) exp_ctl = 6'b110010;
            end

            #1;
            total++; if (ctl !== exp_ctl) begin bad++; $display("[TB] FAIL rnd_ctl @%0d: got %b expected %b", n, ctl, exp_ctl); end
            total++; if (state !== exp_state) begin bad++; $display("[TB] FAIL rnd_state @%0d: got %0d expected %0d", n, state, exp_state); end
            total++; if (mc_error !== (err | err_now)) begin bad++; $display("[TB] FAIL rnd_err @%0d: got %b expected %b", n, mc_error, err | err_now); end
            total++; if (stall_cycles !== 16'(stalls)) begin bad++; $display("[TB] FAIL rnd_cnt @%0d: got %0d expected %0d", n, stall_cycles, stalls); end
            tick();
            if (exp_ctl[5] && stalls < 65535) stalls++;
            err = err | err_now;
            br_left = n_br; mc_on = n_on; mc_paid = n_paid;
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_branch_load_use();
        test_mc_done();
        test_mc_timeout();
        test_reset_mid_op();
        test_random();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
